// File: rtl/sub_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default operand width.
package sub_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/sub_divider_trial_sub.sv
// Combinational WIDTH+1-bit trial subtractor; borrow is the MSB of the difference.
module trial_sub
    import sub_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    // Operands are bounded so a negative result always lands with its MSB set.
    assign diff   = minuend - subtrahend;
    assign borrow = diff[WIDTH];

endmodule

// File: rtl/sub_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle with start/busy/done handshake.
module sub_divider
    import sub_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quot_acc_q;
    logic [WIDTH:0]   rem_acc_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic             unused_bits;

    assign shifted   = {rem_acc_q[WIDTH-1:0], dividend_q[WIDTH-1]};
    assign rem_next  = borrow ? shifted : diff;
    assign quot_next = {quot_acc_q[WIDTH-2:0], ~borrow};

    // Partial remainder stays below the divisor, so these top bits never carry information.
    assign unused_bits = rem_acc_q[WIDTH] ^ quot_acc_q[WIDTH-1];

    trial_sub #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, divisor_q}),
        .diff       (diff),
        .borrow     (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quot_acc_q  <= '0;
            rem_acc_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dividend_q <= A;
                        divisor_q  <= B;
                        if (B != '0) begin
                            rem_acc_q  <= '0;
                            quot_acc_q <= '0;
                            count_q    <= '0;
                            busy_q     <= 1'b1;
                            dbz_q      <= 1'b0;
                            state_q    <= CALC;
                        end else begin
                            // Divide by zero resolves immediately with all-ones quotient.
                            quotient_q  <= '1;
                            remainder_q <= A;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_acc_q  <= rem_next;
                    quot_acc_q <= quot_next;
                    dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
                    count_q    <= count_q + CNT_W'(1);
                    if (count_q == LAST_STEP) begin
                        quotient_q  <= quot_next;
                        remainder_q <= rem_next[WIDTH-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sub_divider.sv
// Scoreboard bench for sub_divider: driver pushes expected results, negedge monitor checks them.
module tb_sub_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;

    always #5 clk = ~clk;

    sub_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (dbz)
    );

    typedef struct {
        int q;
        int r;
        int dz;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc_cnt = 0;
    logic rst_seen = 1'b0;
    bit   mon_en = 1'b0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   dbz_clr_cyc = -1;
    int   held_q = 0;
    int   held_r = 0;
    int   held_dz = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc_cnt);
    endtask

    always @(posedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        rst_seen <= rst;
    end

    // Monitor: compares every cycle against the expectations the driver has published.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            chk("busy", int'(busy), int'(cyc_cnt >= busy_lo && cyc_cnt <= busy_hi));
            if (rst_seen) begin
                held_q  = 0;
                held_r  = 0;
                held_dz = 0;
                chk("rst_done", int'(done), 0);
                chk("rst_quotient", int'(quotient), 0);
                chk("rst_remainder", int'(remainder), 0);
                chk("rst_dbz", int'(dbz), 0);
            end else if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc_cnt, e.cyc);
                    chk("quotient", int'(quotient), e.q);
                    chk("remainder", int'(remainder), e.r);
                    chk("dbz", int'(dbz), e.dz);
                    held_q  = e.q;
                    held_r  = e.r;
                    held_dz = e.dz;
                end
            end else begin
                if (cyc_cnt == dbz_clr_cyc) held_dz = 0;
                chk("hold_quotient", int'(quotient), held_q);
                chk("hold_remainder", int'(remainder), held_r);
                chk("hold_dbz", int'(dbz), held_dz);
                if (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
                    chk("done_pulse", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc_cnt < c) cyc();
    endtask

    // Drives start with operands and publishes the expected outcome of accepting it.
    task automatic issue(input int av, input int bv, output int done_cyc);
        int   n;
        exp_t e;
        n     = cyc_cnt;
        start = 1'b1;
        a     = W'(av);
        b     = W'(bv);
        if (bv == 0) begin
            e.q   = (1 << W) - 1;
            e.r   = av;
            e.dz  = 1;
            e.cyc = n + 1;
        end else begin
            e.q         = av / bv;
            e.r         = av % bv;
            e.dz        = 0;
            e.cyc       = n + 1 + W;
            busy_lo     = n + 1;
            busy_hi     = n + W;
            dbz_clr_cyc = n + 1;
        end
        done_cyc = e.cyc;
        sb.push_back(e);
    endtask

    task automatic run_op(input int av, input int bv);
        int d;
        issue(av, bv, d);
        cyc();
        start = 1'b0;
        wait_until(d + 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        int d;
        int d2;
        int last_done;
        int av;
        int bv;
        int mode;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cyc();
        mon_en = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        run_op(5, 3);
        run_op(10, 2);
        run_op(2, 7);
        run_op(15, 1);
        run_op(9, 0);
        run_op(6, 3);

        // Start during the second busy cycle is ignored.
        n = cyc_cnt;
        issue(13, 4, d);
        cyc();
        start = 1'b0;
        wait_until(n + 2);
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        cyc();
        start = 1'b0;
        wait_until(d + 1);

        // Reset on the third busy cycle aborts without a done pulse.
        n = cyc_cnt;
        issue(12, 5, d);
        cyc();
        start = 1'b0;
        wait_until(n + 3);
        rst = 1'b1;
        cyc();
        sb.delete();
        busy_hi = n + 3;
        rst     = 1'b0;
        cyc();
        run_op(12, 5);

        // Start held through the DONE cycle is accepted back-to-back.
        issue(14, 3, d);
        cyc();
        wait_until(d);
        issue(8, 2, d2);
        cyc();
        start = 1'b0;
        wait_until(d2 + 1);

        last_done = cyc_cnt;
        for (int i = 0; i < 60; i++) begin
            av   = int'($urandom_range(0, 15));
            bv   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            mode = int'($urandom_range(0, 3));
            if (mode == 0) wait_until(last_done);
            else wait_until(last_done + 1 + int'($urandom_range(0, 2)));
            n = cyc_cnt;
            issue(av, bv, last_done);
            cyc();
            start = 1'b0;
            if (bv != 0 && mode == 1) begin
                wait_until(n + int'($urandom_range(1, W - 1)));
                start = 1'b1;
                a     = W'($urandom_range(0, 15));
                b     = W'($urandom_range(0, 15));
                cyc();
                start = 1'b0;
            end
        end
        wait_until(last_done + 3);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
